store_write_ctrl: RTL and testbench

Multi-cycle store sequencer for the RV32I core. It is the write-side counterpart of the load path. It accepts a decoded S-type store (funct3, effective address from the ALU, rs2 data) and performs a single aligned word-bus write with lane replication and byte enables. It uses a req/ack handshake to data memory, with alignment checking and an ack timeout, and reports completion to the control unit with a one-cycle done pulse.

---
 rtl/store_write_ctrl.sv | 175 +++++++++++++++++
 tb/tb_store_write_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_ctrl.sv
// store_write_ctrl: multi-cycle RV32I store sequencer.
// Accepts a decoded S-type store and performs one aligned word-bus write with lane
// replication and byte enables over a req/ack handshake. Misaligned or illegal
// stores are rejected without touching memory. A missing ack aborts the write after
// TIMEOUT_CYCLES cycles. Every outcome ends with a one-cycle done pulse.
// All outputs decode from state and captured registers only, so no input reaches an
// output combinationally.
module store_write_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic        timeout_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack
);

    // Wide enough to hold TIMEOUT_CYCLES-1. The REQ state exits at that value,
    // so the counter never needs to saturate.
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_timeout;
    logic             w_timeout_next;
    logic             w_capture;

    // Captured at acceptance so the bus stays stable for the whole REQ state.
    logic [2:0]       r_funct3;
    logic [31:0]      r_word_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;

    logic             w_misalign;
    logic [31:0]      w_lane_wdata;
    logic [3:0]       w_lane_be;

    // Alignment check on the incoming request. Illegal funct3 is also rejected here.
    always_comb begin
        w_misalign = 1'b0;
        unique case (funct3)
            F3_SB:   w_misalign = 1'b0;
            F3_SH:   w_misalign = addr[0];
            F3_SW:   w_misalign = (addr[1:0] != 2'b00);
            default: w_misalign = 1'b1;
        endcase
    end

    // Lane replication and byte-enable generation for the incoming request.
    always_comb begin
        w_lane_wdata = 32'h0;
        w_lane_be    = 4'b0000;
        unique case (funct3)
            F3_SB: begin
                w_lane_wdata = {4{rs2_data[7:0]}};
                w_lane_be    = 4'b0001 << addr[1:0];
            end
            F3_SH: begin
                w_lane_wdata = {2{rs2_data[15:0]}};
                w_lane_be    = addr[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW: begin
                w_lane_wdata = rs2_data;
                w_lane_be    = 4'b1111;
            end
            default: begin
                w_lane_wdata = 32'h0;
                w_lane_be    = 4'b0000;
            end
        endcase
    end

    // Next-state logic: acceptance in IDLE, ack/timeout resolution in REQ.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_timeout_next = r_timeout;
        w_capture      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture      = 1'b1;
                    w_timeout_next = 1'b0;
                    w_cnt_next     = '0;
                    w_state_next   = w_misalign ? ERR : REQ;
                end
            end
            REQ: begin
                // Ack takes priority over a timeout expiring on the same edge.
                if (mem_ack) begin
                    w_state_next = DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next   = ERR;
                    w_timeout_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            DONE: w_state_next = IDLE;
            ERR:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State, counter and error-kind registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Request capture: loaded only when a start is accepted in IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_funct3    <= 3'b000;
            r_word_addr <= 32'h0;
            r_wdata     <= 32'h0;
            r_be        <= 4'b0000;
        end else if (w_capture) begin
            r_funct3    <= funct3;
            r_word_addr <= {addr[31:2], 2'b00};
            r_wdata     <= w_lane_wdata;
            r_be        <= w_lane_be;
        end
    end

    // Output decode from registered state only. The bus is zero outside REQ.
    always_comb begin
        busy        = (r_state != IDLE);
        done        = (r_state == DONE) || (r_state == ERR);
        misalign    = (r_state == ERR) && !r_timeout;
        timeout_err = (r_state == ERR) && r_timeout;
        mem_req     = (r_state == REQ);
        mem_we      = (r_state == REQ);
        mem_addr    = (r_state == REQ) ? r_word_addr : 32'h0;
        mem_wdata   = (r_state == REQ) ? r_wdata : 32'h0;
        mem_be      = (r_state == REQ) ? r_be : 4'b0000;
    end

    // Captured funct3 is retained for debug visibility; it does not feed the outputs.
    logic w_funct3_unused;
    assign w_funct3_unused = ^r_funct3;

endmodule

// File: tb/tb_store_write_ctrl.sv
// Scoreboard testbench for store_write_ctrl.
// The driver issues stores and pushes the expected outcome from a behavioural model
// into a queue. A negedge monitor checks the bus every REQ cycle and pops the queue
// on each done pulse.
module tb_store_write_ctrl;

    localparam int unsigned TO = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] rs2_data = 32'h0;
    logic        mem_ack = 1'b0;
    logic        busy, done, misalign, timeout_err, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    store_write_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .start(start), .funct3(funct3), .addr(addr),
        .rs2_data(rs2_data), .busy(busy), .done(done), .misalign(misalign),
        .timeout_err(timeout_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          mis;
        bit          to;
        int          req_cycles;
        int          done_cyc;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome from the architectural store rules. ack_n is the REQ cycle in
    // which the bench raises mem_ack (values beyond TO never arrive in time).
    function automatic exp_t model(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] d, input int ack_n);
        exp_t e;
        int   off;
        off     = int'(a % 4);
        e.mis   = (f > 3'd2) || (f == 3'd1 && off % 2 != 0) || (f == 3'd2 && off != 0);
        e.write = !e.mis;
        e.addr  = a - 32'(off);
        e.wdata = 32'h0;
        e.be    = 4'h0;
        case (f)
            3'd0: begin
                e.wdata = 32'(d[7:0]) * 32'h0101_0101;
                e.be    = 4'(1 << off);
            end
            3'd1: begin
                e.wdata = 32'(d[15:0]) * 32'h0001_0001;
                e.be    = (off >= 2) ? 4'hC : 4'h3;
            end
            3'd2: begin
                e.wdata = d;
                e.be    = 4'hF;
            end
            default: ;
        endcase
        if (e.mis) begin
            e.req_cycles = 0;
            e.to         = 1'b0;
        end else if (ack_n <= int'(TO)) begin
            e.req_cycles = ack_n;
            e.to         = 1'b0;
        end else begin
            e.req_cycles = int'(TO);
            e.to         = 1'b1;
        end
        e.done_cyc = 0;
        return e;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("idle_wait", busy, 0);
    endtask

    // One store. mid_start pulses a stray start in REQ cycle 2; done_start raises
    // start while done is showing. Both must be ignored.
    task automatic run_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                             input int ack_n, input bit mid_start, input bit done_start);
        exp_t e;
        wait_idle();
        funct3   = f;
        addr     = a;
        rs2_data = d;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        start      = 1'b0;
        e          = model(f, a, d, ack_n);
        e.done_cyc = cyc + e.req_cycles;
        sbq.push_back(e);
        // Scramble inputs so any late capture shows up on the bus.
        funct3   = 3'($urandom);
        addr     = $urandom;
        rs2_data = $urandom;
        if (!e.mis) begin
            for (int c = 1; c <= ack_n; c++) begin
                mem_ack = (c == ack_n);
                start   = mid_start && (c == 2);
                @(posedge CLK);
                #1;
                start = 1'b0;
            end
            mem_ack = 1'b0;
        end
        if (done_start && (e.mis || ack_n <= int'(TO))) begin
            funct3 = 3'd2;
            addr   = {$urandom} & 32'hFFFF_FFFC;
            start  = 1'b1;
            @(posedge CLK);
            #1;
            start = 1'b0;
        end
        repeat ($urandom_range(0, 2)) @(posedge CLK);
        #1;
    endtask

    // Monitor: bus contents and stability every REQ cycle, outcome on each done.
    initial begin : monitor
        int   req_cnt = 0;
        bit   prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                req_cnt   = 0;
                prev_done = 1'b0;
            end else begin
                check("we_eq_req", mem_we, mem_req);
                check("busy", busy, mem_req | done);
                check("done_pulse", done & prev_done, 0);
                if (mem_req) begin
                    req_cnt++;
                    if (sbq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_req: mem_req=1 with no store pending");
                    end else if (!sbq[0].write) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rejected_req: mem_req=1 for a rejected store");
                    end else begin
                        check("mem_addr", mem_addr, sbq[0].addr);
                        check("mem_wdata", mem_wdata, sbq[0].wdata);
                        check("mem_be", mem_be, sbq[0].be);
                    end
                end else begin
                    check("addr_idle_zero", mem_addr, 0);
                    check("wdata_idle_zero", mem_wdata, 0);
                    check("be_idle_zero", mem_be, 0);
                end
                if (done) begin
                    if (sbq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: done=1 with no store pending");
                    end else begin
                        e = sbq.pop_front();
                        check("misalign", misalign, e.mis);
                        check("timeout_err", timeout_err, e.to);
                        check("req_cycles", req_cnt, e.req_cycles);
                        check("done_cycle", cyc, e.done_cyc);
                    end
                    req_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [2:0]  f;
        logic [31:0] a;
        exp_t        e;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_be", mem_be, 0);
        check("rst_flags", {misalign, timeout_err, mem_we}, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Directed cases.
        run_store(3'd2, 32'h0000_1004, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
        run_store(3'd0, 32'h0000_2003, 32'h0000_00A5, 2, 1'b0, 1'b0);
        run_store(3'd1, 32'h0000_2002, 32'h0000_1234, 1, 1'b0, 1'b0);
        run_store(3'd2, 32'h0000_1002, 32'h1111_2222, 1, 1'b0, 1'b0);
        run_store(3'd1, 32'h0000_1001, 32'h3333_4444, 1, 1'b0, 1'b0);
        run_store(3'd3, 32'h0000_1000, 32'h5555_6666, 1, 1'b0, 1'b0);
        run_store(3'd2, 32'h0000_4000, 32'hCAFE_F00D, TO + 2, 1'b0, 1'b0);
        run_store(3'd2, 32'h0000_4004, 32'h0BAD_F00D, TO, 1'b0, 1'b0);
        run_store(3'd0, 32'h0000_5001, 32'h0000_0077, TO, 1'b1, 1'b1);
        run_store(3'd1, 32'h0000_5003, 32'h0000_9999, 1, 1'b0, 1'b1);

        // Randomized stores.
        for (int i = 0; i < 150; i++) begin
            f = ($urandom_range(0, 7) < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_store(f, a, $urandom, int'($urandom_range(1, TO + 2)),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of a REQ cycle.
        wait_idle();
        funct3   = 3'd2;
        addr     = 32'h0000_3000;
        rs2_data = 32'h1357_9BDF;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        start      = 1'b0;
        e          = model(3'd2, 32'h0000_3000, 32'h1357_9BDF, TO + 2);
        e.done_cyc = cyc + e.req_cycles;
        sbq.push_back(e);
        @(posedge CLK);
        #2;
        check("pre_rst_req", mem_req, 1);
        RST = 1'b1;
        #1;
        check("async_rst_req", mem_req, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        sbq.delete();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        run_store(3'd0, 32'h0000_6002, 32'h0000_00C3, 2, 1'b0, 1'b0);
        run_store(3'd2, 32'h0000_6008, 32'h2468_ACE0, 1, 1'b0, 1'b0);

        wait_idle();
        repeat (3) @(posedge CLK);
        #1;
        check("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
